// File: rtl/ad_cache_mc.sv
// ad_cache_mc: multi-channel ADC window capture into a ping-pong RAM, drained word-wise.
// Optional macro AD_CACHE_SEQ_EN adds a per-bank completion sequence number (bank_seq).
module ad_cache_mc #(
  parameter int CH_NUM     = 2,
  parameter int AD_NBIT    = 16,
  parameter int SLOT_NBIT  = 24,
  parameter int OUT_NBIT   = 16,
  parameter int BANK_DEPTH = 256,
  parameter int SP_START   = 0,
  parameter int SP_NUM     = 256
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sync,
  input  logic                      spclk,
  input  logic [CH_NUM*AD_NBIT-1:0] wdata,
  input  logic                      rd,
  output logic [OUT_NBIT-1:0]       rdata,
  output logic                      rvalid,
  output logic                      bank_ready,
  input  logic                      bank_ack,
  output logic                      switch,
  output logic                      overflow
`ifdef AD_CACHE_SEQ_EN
  ,
  output logic [15:0]               bank_seq
`endif
);

  localparam int ENT_W = CH_NUM * SLOT_NBIT;
  localparam int W     = ENT_W / OUT_NBIT;
  localparam int WI_W  = (W > 1) ? $clog2(W) : 1;
  localparam int AW    = $clog2(BANK_DEPTH);
  localparam int CNT_W = $clog2(SP_START + SP_NUM + 2);

  localparam logic [WI_W-1:0]  WLAST  = WI_W'(W - 1);
  localparam logic [CNT_W-1:0] WIN_LO = CNT_W'(SP_START);
  localparam logic [CNT_W-1:0] WIN_N  = CNT_W'(SP_NUM);

  logic [2:0]       sync_sr, spclk_sr;
  logic             sync_rise, spclk_rise, dis;
  logic [CNT_W-1:0] spclk_cnt;
  logic             cache_en, in_win;
  logic [ENT_W-1:0] entry, pend, ent;
  logic             pend_v;

  logic [1:0]       full;
  logic             wbank, rbank;
  logic [AW-1:0]    waddr, raddr;
  logic [WI_W-1:0]  widx, rd_w;
  logic             ack_fire, rd_fire, blocked, we;
  logic             rd_v;
  logic [AW:0]      rd_a;
  logic [OUT_NBIT-1:0] rd_word;

  logic [ENT_W-1:0] mem [2*BANK_DEPTH];

  assign sync_rise  = sync_sr[1] & ~sync_sr[2];
  assign spclk_rise = spclk_sr[1] & ~spclk_sr[2];
  assign dis        = sync_rise & ~en;
  // Wrapping subtract keeps the window test free of a lower-bound compare.
  assign in_win     = (spclk_cnt - WIN_LO) < WIN_N;

  always_comb begin
    entry = '0;
    for (int c = 0; c < CH_NUM; c++)
      entry[c*SLOT_NBIT +: SLOT_NBIT] =
        SLOT_NBIT'($signed(wdata[c*AD_NBIT +: AD_NBIT]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_sr   <= '0;
      spclk_sr  <= '0;
      spclk_cnt <= '0;
      cache_en  <= 1'b0;
      pend_v    <= 1'b0;
      pend      <= '0;
    end else begin
      sync_sr  <= {sync_sr[1:0], sync};
      spclk_sr <= {spclk_sr[1:0], spclk};
      pend_v   <= 1'b0;
      if (sync_rise) begin
        spclk_cnt <= '0;
        cache_en  <= en;
      end else if (spclk_rise && cache_en) begin
        if (~&spclk_cnt) spclk_cnt <= spclk_cnt + 1'b1;
        pend_v <= in_win;
        pend   <= entry;
      end
    end
  end

  assign bank_ready = full[rbank];
  assign switch     = rbank;
  assign ack_fire   = bank_ack & full[rbank];
  assign rd_fire    = rd & full[rbank];
  // An ack of the bank the writer waits on frees it for this very write.
  assign blocked    = full[wbank] & ~(ack_fire & (rbank == wbank));
  assign we         = pend_v & ~dis & ~blocked;

  always_ff @(posedge clk) begin
    if (rst) begin
      wbank    <= 1'b0;
      waddr    <= '0;
      full     <= '0;
      rbank    <= 1'b0;
      raddr    <= '0;
      widx     <= '0;
      overflow <= 1'b0;
    end else if (dis) begin
      wbank <= 1'b0;
      waddr <= '0;
      full  <= '0;
      rbank <= 1'b0;
    end else begin
      if (sync_rise) overflow <= 1'b0;
      if (rd_fire) begin
        if (widx == WLAST) begin
          widx  <= '0;
          raddr <= raddr + 1'b1;
        end else begin
          widx <= widx + 1'b1;
        end
      end
      if (ack_fire) begin
        full[rbank] <= 1'b0;
        rbank       <= ~rbank;
        raddr       <= '0;
        widx        <= '0;
      end
      if (pend_v) begin
        if (blocked) begin
          overflow <= 1'b1;
        end else begin
          waddr <= waddr + 1'b1;
          if (&waddr) begin
            full[wbank] <= 1'b1;
            wbank       <= ~wbank;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{wbank, waddr}] <= pend;
  end

  assign ent     = mem[rd_a];
  assign rd_word = ent[int'(WLAST - rd_w)*OUT_NBIT +: OUT_NBIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v   <= 1'b0;
      rd_a   <= '0;
      rd_w   <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rd_v   <= rd_fire;
      rd_a   <= {rbank, raddr};
      rd_w   <= widx;
      rvalid <= rd_v;
      if (rd_v) rdata <= rd_word;
    end
  end

`ifdef AD_CACHE_SEQ_EN
  logic [15:0] seq_cnt;
  logic [15:0] seq_mem [2];

  always_ff @(posedge clk) begin
    if (rst || dis) begin
      seq_cnt <= '0;
    end else if (we && (&waddr)) begin
      seq_mem[wbank] <= seq_cnt;
      seq_cnt        <= seq_cnt + 1'b1;
    end
  end

  assign bank_seq = bank_ready ? seq_mem[rbank] : '0;
`endif

endmodule

// File: doc/ad_cache_mc.md
Name: ad_cache_mc

Overview:
Multi-channel successor to the single-channel AD sample cache. It captures a window of parallel ADC samples after each frame sync and sign-extends every channel into a fixed slot. Samples are packed one entry per sample edge into an internal two-bank (ping-pong) RAM. A downstream USB/host reader drains each full bank in OUT_NBIT words, using an explicit ready/ack handshake with overflow detection. Single clock domain; sits between the ADC interface and the USB FIFO writer.

Parameters:
CH_NUM, 2, ADC channels captured per sample edge.
AD_NBIT, 16, raw sample width per channel (AD_NBIT <= SLOT_NBIT).
SLOT_NBIT, 24, sign-extended slot width per channel.
OUT_NBIT, 16, read word width; CH_NUM*SLOT_NBIT must be an integer multiple of OUT_NBIT.
BANK_DEPTH, 256, entries per bank; power of 2.
SP_START, 0, first captured spclk edge index after sync.
SP_NUM, 256, number of spclk edges captured per sync window.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  capture enable, sampled at sync rising edge
sync  in  1  frame sync, asynchronous level; 2-FF synchronised internally
spclk  in  1  ADC sample strobe, asynchronous level; 2-FF synchronised, rising edge used
wdata  in  CH_NUM*AD_NBIT  channel samples, ch0 in LSBs; sampled when the spclk edge is detected
rd  in  1  read strobe, one word per asserted cycle
rdata  out  OUT_NBIT  read word
rvalid  out  1  rdata valid
bank_ready  out  1  read bank is full and readable
bank_ack  in  1  consumer has finished the current read bank
switch  out  1  index of the current read bank
overflow  out  1  sticky: a capture was dropped because the write bank was still full

Behaviour:
- Reset: rdata=0, rvalid=0, bank_ready=0, switch=0, overflow=0. Write bank=0, read bank=0, both full flags=0, waddr=0, raddr=0, word index=0, spclk_cnt=0, cache_en=0.
- Sync rising edge (after synchroniser):
  - spclk_cnt<=0; cache_en<=en.
  - If en=1, overflow<=0.
  - If en=0: waddr<=0, write bank<=0, both full flags<=0, read bank<=0.
- Capture:
  - On each detected spclk rising edge with cache_en=1, spclk_cnt increments (saturates at all-ones).
  - An entry is written when the pre-increment count lies in [SP_START, SP_START+SP_NUM).
  - Entry = {chCH_NUM-1 … ch0}, each channel sign-extended to SLOT_NBIT; ch0 in LSBs.
  - RAM write occurs 1 cycle after edge detection.
- Write addressing:
  - waddr increments per entry.
  - At waddr=BANK_DEPTH-1: waddr<=0, full[wbank]<=1, wbank toggles.
- Full write bank: if full[wbank]=1 at a capture, the entry is discarded, waddr holds, and overflow<=1 (sticky). Capture resumes at the held address once the bank is acked.
- Read:
  - bank_ready = full[rbank]; switch = rbank.
  - W = CH_NUM*SLOT_NBIT/OUT_NBIT words per entry, issued MSB word first.
  - rd with bank_ready=1 advances (raddr, widx): widx wraps at W-1 and then raddr increments; raddr wraps to 0 after BANK_DEPTH-1, which re-reads the same bank.
  - Latency: rd in cycle n -> rvalid=1 with rdata in cycle n+2.
  - rd with bank_ready=0 is ignored; rvalid stays 0.
- bank_ack:
  - With bank_ready=1: full[rbank]<=0, rbank toggles, raddr<=0, widx<=0. In-flight reads still complete.
  - With bank_ready=0: ignored.
- Simultaneous events:
  - A write completing bank X and an ack of bank Y (Y≠X) in the same cycle: both take effect.
  - Ack of the bank the writer is waiting on, in the same cycle as a capture: the capture is written, not dropped.
  - rd and bank_ack in the same cycle: the rd is served from the old bank; the ack then applies.
- rst mid-operation: everything returns to reset values next cycle; RAM contents undefined.

Optional Feature:
AD_CACHE_SEQ_EN.
- Defined: adds output bank_seq[15:0].
  - A 16-bit counter increments, wrapping, each time a bank completes. It is stored per bank.
  - bank_seq shows the value for rbank while bank_ready=1, else 0.
  - The counter resets to 0 on rst and on a sync with en=0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Configuration for tests 1-2: CH_NUM=2, AD_NBIT=16, SLOT_NBIT=24, OUT_NBIT=16, BANK_DEPTH=4.
2. Reset test: assert rst 3 cycles -> all outputs 0; rd pulses give rvalid=0.
3. Capture and read: en=1, sync pulse, 4 spclk edges with ch0=0x8001, ch1=0x0002 -> bank_ready=1, switch=0. 12 rd pulses -> rdata repeats 0x0000, 0x02FF, 0x8001 (×4), each 2 cycles after its rd. bank_ack -> bank_ready=0, switch=1.
4. Window: SP_START=2, SP_NUM=4, BANK_DEPTH=4, edges carry ch0=0..7 -> bank holds ch0 = 2, 3, 4, 5 only.
5. Overflow: BANK_DEPTH=4, 12 edges, no ack -> both banks full, overflow=1 after the 9th edge. Bank 0 reads back edges 0-3. Ack bank 0 -> the next capture lands in bank 0 at addr 0.
6. Disable: sync with en=0, then 10 edges -> no bank_ready and overflow unchanged. Sync with en=1 -> writes restart at bank 0, addr 0, and overflow clears.
7. AD_CACHE_SEQ_EN: 3 banks filled and acked -> bank_seq reads 0, 1, 2.
